icache_responder: RTL and testbench

- Direct-mapped instruction cache that answers fetch-stage instruction requests.
- Sits between the fetch-stage PC and a slower backing instruction memory.
- Hits return the instruction combinationally in the same cycle.
- Misses raise a stall (ORed into StallF by the hazard unit) and run a burst refill over a request/beat handshake.

---
 rtl/icache_responder.sv | 158 +++++++++++++++
 tb/tb_icache_responder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_responder.sv
`default_nettype none
// ============================================================================
// Module   : icache_responder
// Purpose  : Direct-mapped instruction cache for the fetch stage; same-cycle
//            hits, stall plus burst refill over a request/beat handshake on miss.
// Revision : 1.0 - initial release
// ============================================================================
module icache_responder #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SETS       = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] PC_i,
  input  logic                  InvAll_i,
  output logic [DATA_WIDTH-1:0] Instr_o,
  output logic                  StallI_o,
  output logic                  MemReq_o,
  output logic [DATA_WIDTH-1:0] MemAddr_o,
  input  logic                  MemValid_i,
  input  logic [DATA_WIDTH-1:0] MemData_i
);

  localparam int C_WORD_BITS = $clog2(WORDS_PER_LINE);
  localparam int C_SET_BITS  = $clog2(NUM_SETS);
  localparam int C_TAG_LSB   = 2 + C_WORD_BITS + C_SET_BITS;
  localparam int C_TAG_BITS  = DATA_WIDTH - C_TAG_LSB;

  localparam logic [DATA_WIDTH-1:0]  C_NOP       = DATA_WIDTH'(32'h0000_0013);
  localparam logic [C_WORD_BITS-1:0] C_LAST_BEAT = C_WORD_BITS'(WORDS_PER_LINE - 1);

  localparam logic [0:0] C_ST_LOOKUP = 1'b0;
  localparam logic [0:0] C_ST_REFILL = 1'b1;

  logic [0:0] r_state;
  logic [0:0] w_state_nxt;

  logic                  r_valid [NUM_SETS];
  logic [C_TAG_BITS-1:0] r_tag   [NUM_SETS];
  logic [DATA_WIDTH-1:0] r_data  [NUM_SETS][WORDS_PER_LINE];

  logic [C_TAG_BITS-1:0]  r_miss_tag;
  logic [C_SET_BITS-1:0]  r_miss_set;
  logic [C_WORD_BITS-1:0] r_beat;

  logic [C_WORD_BITS-1:0] w_pc_word;
  logic [C_SET_BITS-1:0]  w_pc_set;
  logic [C_TAG_BITS-1:0]  w_pc_tag;
  logic                   w_hit;
  logic                   w_miss;
  logic                   w_beat_we;
  logic                   w_fill_done;
  logic [DATA_WIDTH-1:0]  w_miss_base;
  logic                   w_unused_pc_lsb;

  assign w_pc_word = PC_i[2 +: C_WORD_BITS];
  assign w_pc_set  = PC_i[2 + C_WORD_BITS +: C_SET_BITS];
  assign w_pc_tag  = PC_i[DATA_WIDTH-1 -: C_TAG_BITS];

  // Instructions are word aligned, so the byte offset carries no information.
  assign w_unused_pc_lsb = ^PC_i[1:0];

  assign w_hit       = r_valid[w_pc_set] && (r_tag[w_pc_set] == w_pc_tag);
  assign w_miss      = (r_state == C_ST_LOOKUP) && !w_hit;
  assign w_beat_we   = (r_state == C_ST_REFILL) && MemValid_i;
  assign w_fill_done = w_beat_we && (r_beat == C_LAST_BEAT);
  assign w_miss_base = {r_miss_tag, r_miss_set, {(C_TAG_LSB - C_SET_BITS){1'b0}}};

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= C_ST_LOOKUP;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      C_ST_LOOKUP: if (w_miss)      w_state_nxt = C_ST_REFILL;
      C_ST_REFILL: if (w_fill_done) w_state_nxt = C_ST_LOOKUP;
      default:                      w_state_nxt = C_ST_LOOKUP;
    endcase
  end

  // Outputs are forced low while reset is held so an aborted burst drops at once.
  always_comb begin
    Instr_o   = '0;
    StallI_o  = 1'b0;
    MemReq_o  = 1'b0;
    MemAddr_o = '0;
    if (!rst) begin
      MemAddr_o = w_miss_base;
      case (r_state)
        C_ST_LOOKUP: begin
          if (w_hit) begin
            Instr_o = r_data[w_pc_set][w_pc_word];
          end else begin
            Instr_o  = C_NOP;
            StallI_o = 1'b1;
          end
        end
        C_ST_REFILL: begin
          Instr_o  = C_NOP;
          StallI_o = 1'b1;
          MemReq_o = 1'b1;
        end
        default: begin
          Instr_o = C_NOP;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- miss tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_miss_tag <= '0;
      r_miss_set <= '0;
      r_beat     <= '0;
    end else if (w_miss) begin
      r_miss_tag <= w_pc_tag;
      r_miss_set <= w_pc_set;
      r_beat     <= '0;
    end else if (w_beat_we) begin
      r_beat <= r_beat + C_WORD_BITS'(1);
    end
  end

  // ---------------------------------------------------------------- storage
  // Invalidate is checked first so it wins over a coincident last beat.
  generate
    for (genvar s = 0; s < NUM_SETS; s++) begin : g_valid
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_valid[s] <= 1'b0;
        end else if (InvAll_i) begin
          r_valid[s] <= 1'b0;
        end else if (w_fill_done && (r_miss_set == C_SET_BITS'(s))) begin
          r_valid[s] <= 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_beat_we) begin
      r_data[r_miss_set][r_beat] <= MemData_i;
    end
    if (w_fill_done) begin
      r_tag[r_miss_set] <= r_miss_tag;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icache_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_responder
// Purpose  : Directed plus randomized check of icache_responder against a
//            set/tag/word array model of a direct-mapped cache.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache_responder;

  localparam logic [31:0] C_NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [31:0] PC_i;
  logic        InvAll_i;
  logic [31:0] Instr_o;
  logic        StallI_o;
  logic        MemReq_o;
  logic [31:0] MemAddr_o;
  logic        MemValid_i;
  logic [31:0] MemData_i;

  int n_cmp = 0;
  int n_err = 0;

  bit          m_valid [64];
  logic [31:0] m_tag   [64];
  logic [31:0] m_data  [64][4];

  icache_responder #(.DATA_WIDTH(32), .NUM_SETS(64), .WORDS_PER_LINE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .PC_i      (PC_i),
    .InvAll_i  (InvAll_i),
    .Instr_o   (Instr_o),
    .StallI_o  (StallI_o),
    .MemReq_o  (MemReq_o),
    .MemAddr_o (MemAddr_o),
    .MemValid_i(MemValid_i),
    .MemData_i (MemData_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int set_of(input logic [31:0] a);
    return int'((a >> 4) % 64);
  endfunction
  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a >> 10;
  endfunction
  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) % 4);
  endfunction

  // Backing memory contents: the boot program at the reset vector, a hash elsewhere.
  function automatic logic [31:0] mem_at(input logic [31:0] a);
    case (a)
      32'hBFC0_0000: return 32'h0050_0093;
      32'hBFC0_0004: return 32'h0010_0113;
      32'hBFC0_0008: return 32'h0020_81B3;
      32'hBFC0_000C: return 32'h0000_0013;
      default:       return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endcase
  endfunction

  task automatic clear_model();
    for (int s = 0; s < 64; s++) m_valid[s] = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // One fetch of pc, servicing any refill with `gap` idle cycles before each beat.
  task automatic fetch(input logic [31:0] pc, input int gap, input bit inv_last,
                       input bit inv_look, input bit redirect, input logic [31:0] new_pc,
                       output int stalls);
    logic [31:0] cur;
    logic [31:0] base;
    int          passes;
    bit          done;
    bit          hit;
    int          s;
    cur    = pc;
    stalls = 0;
    passes = 0;
    done   = 1'b0;
    while (!done) begin
      PC_i       = cur;
      MemValid_i = 1'($urandom_range(0, 1));
      MemData_i  = $urandom;
      InvAll_i   = inv_look && (passes == 0);
      @(negedge clk);
      s   = set_of(cur);
      hit = m_valid[s] && (m_tag[s] == tag_of(cur));
      if (hit) begin
        chk("hit_instr", Instr_o, m_data[s][word_of(cur)]);
        chk("hit_stall", 32'(StallI_o), 32'd0);
        chk("hit_memreq", 32'(MemReq_o), 32'd0);
        done = 1'b1;
      end else begin
        chk("miss_instr", Instr_o, C_NOP);
        chk("miss_stall", 32'(StallI_o), 32'd1);
        chk("miss_memreq", 32'(MemReq_o), 32'd0);
        stalls++;
      end
      @(posedge clk);
      #1;
      if (InvAll_i) clear_model();
      InvAll_i   = 1'b0;
      MemValid_i = 1'b0;
      if (!done) begin
        base = {cur[31:4], 4'b0000};
        if (redirect) cur = new_pc;
        PC_i = cur;
        for (int b = 0; b < 4; b++) begin
          for (int g = 0; g <= gap; g++) begin
            MemValid_i = (g == gap);
            MemData_i  = (g == gap) ? mem_at(base + 32'(4 * b)) : $urandom;
            InvAll_i   = inv_last && (passes == 0) && (b == 3) && (g == gap);
            @(negedge clk);
            chk("refill_memreq", 32'(MemReq_o), 32'd1);
            chk("refill_addr", MemAddr_o, base);
            chk("refill_stall", 32'(StallI_o), 32'd1);
            chk("refill_instr", Instr_o, C_NOP);
            stalls++;
            @(posedge clk);
            #1;
            if (MemValid_i) m_data[set_of(base)][b] = MemData_i;
            if (MemValid_i && b == 3) begin
              m_tag[set_of(base)]   = tag_of(base);
              m_valid[set_of(base)] = 1'b1;
            end
            if (InvAll_i) clear_model();
            MemValid_i = 1'b0;
            InvAll_i   = 1'b0;
          end
        end
        passes++;
        if (passes > 3) begin
          chk("refill_loop_bound", 32'(passes), 32'd3);
          done = 1'b1;
        end
      end
    end
  endtask

  logic [31:0] pool [3];
  logic [31:0] rpc;
  logic [31:0] rpc2;
  int          st;

  function automatic logic [31:0] rand_pc();
    return pool[$urandom_range(0, 2)] | (32'($urandom_range(0, 3)) << 4)
           | (32'($urandom_range(0, 3)) << 2);
  endfunction

  initial begin
    pool[0] = 32'hBFC0_0000;
    pool[1] = 32'hBFC0_0400;
    pool[2] = 32'h0000_1000;
    rst        = 1'b0;
    PC_i       = 32'hBFC0_0000;
    InvAll_i   = 1'b0;
    MemValid_i = 1'b0;
    MemData_i  = 32'h0;
    clear_model();
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_memreq", 32'(MemReq_o), 32'd0);
    chk("reset_addr", MemAddr_o, 32'd0);
    chk("reset_stall", 32'(StallI_o), 32'd0);
    chk("reset_instr", Instr_o, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Cold miss at the reset vector, then hits across the same line.
    fetch(32'hBFC0_0000, 0, 1'b0, 1'b0, 1'b0, 32'h0, st);
    chk("cold_stall_cycles", 32'(st), 32'd5);
    fetch(32'hBFC0_0004, 0, 1'b0, 1'b0, 1'b0, 32'h0, st);
    chk("hit1_stall_cycles", 32'(st), 32'd0);
    fetch(32'hBFC0_0008, 0, 1'b0, 1'b0, 1'b0, 32'h0, st);
    chk("hit2_stall_cycles", 32'(st), 32'd0);
    fetch(32'hBFC0_000C, 0, 1'b0, 1'b0, 1'b0, 32'h0, st);
    chk("hit3_stall_cycles", 32'(st), 32'd0);

    // Conflict miss in set 0, then the original line misses again.
    fetch(32'hBFC0_0400, 0, 1'b0, 1'b0, 1'b0, 32'h0, st);
    chk("conflict_stall_cycles", 32'(st), 32'd5);
    fetch(32'hBFC0_0000, 0, 1'b0, 1'b0, 1'b0, 32'h0, st);
    chk("conflict_back_stall_cycles", 32'(st), 32'd5);

    // Two idle cycles ahead of every beat.
    fetch(32'h0000_1018, 2, 1'b0, 1'b0, 1'b0, 32'h0, st);
    chk("gapped_stall_cycles", 32'(st), 32'd13);

    // Invalidate on the last beat leaves the line invalid, so it refills twice.
    fetch(32'hBFC0_0024, 0, 1'b1, 1'b0, 1'b0, 32'h0, st);
    chk("inv_collision_stall_cycles", 32'(st), 32'd10);

    // Reset asserted mid-cycle after beat 1 of a refill.
    PC_i = 32'h0000_2040;
    @(posedge clk);
    #1;
    for (int b = 0; b < 2; b++) begin
      MemValid_i = 1'b1;
      MemData_i  = mem_at(32'h0000_2040 + 32'(4 * b));
      @(posedge clk);
      #1;
    end
    MemValid_i = 1'b0;
    chk("pre_reset_memreq", 32'(MemReq_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_memreq", 32'(MemReq_o), 32'd0);
    chk("async_reset_stall", 32'(StallI_o), 32'd0);
    chk("async_reset_instr", Instr_o, 32'd0);
    chk("async_reset_addr", MemAddr_o, 32'd0);
    clear_model();
    @(posedge clk);
    #1 rst = 1'b0;
    fetch(32'h0000_2048, 0, 1'b0, 1'b0, 1'b0, 32'h0, st);
    chk("post_reset_stall_cycles", 32'(st), 32'd5);

    // Randomized traffic: conflicts, gaps, redirects, invalidates, stray beats.
    for (int i = 0; i < 150; i++) begin
      rpc  = rand_pc();
      rpc2 = rand_pc();
      fetch(rpc, int'($urandom_range(0, 2)), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0), rpc2, st);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
